// File: rtl/multicycle_mem.sv
// Responder end of the multi-cycle datapath memory bus: a word-addressed
// memory that accepts one request from IDLE and answers LATENCY cycles later
// with a one-cycle ready pulse, registered read data and an error flag.
module multicycle_mem #(
   parameter int DEPTH_WORDS = 64,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  be,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err,
   output logic        busy
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ready_q, ready_d;
   logic        err_q, err_d;
   logic        busy_q, busy_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic             txn_we;
   logic [31:0]      txn_addr;
   logic [31:0]      txn_wdata;
   logic [3:0]       txn_be;
   logic [IDX_W-1:0] txn_idx;
   logic [31:0]      txn_upper;
   logic             txn_valid;
   logic             enter_resp;
   logic             mem_we;

   // Transaction being completed: live inputs when completing on the accepting
   // edge (LATENCY=1), otherwise the request captured at acceptance.
   always_comb begin
      if (state_q == IDLE) begin
         txn_we    = we;
         txn_addr  = addr;
         txn_wdata = wdata;
         txn_be    = be;
      end else begin
         txn_we    = we_q;
         txn_addr  = addr_q;
         txn_wdata = wdata_q;
         txn_be    = be_q;
      end
      txn_idx   = txn_addr[IDX_W+1:2];
      txn_upper = txn_addr >> (IDX_W + 2);
      txn_valid = (txn_addr[1:0] == 2'b00) && (txn_upper == 32'd0);
   end

   // Next-state, request capture and registered response computation.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      rdata_d    = rdata_q;
      enter_resp = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               we_d    = we;
               addr_d  = addr;
               wdata_d = wdata;
               be_d    = be;
               if (LATENCY == 1) begin
                  state_d    = RESP;
                  cnt_d      = 4'd0;
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 4'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (enter_resp) begin
         if (!txn_valid) begin
            rdata_d = 32'd0;
         end else if (!txn_we) begin
            rdata_d = mem[txn_idx];
         end
      end
      ready_d = enter_resp;
      err_d   = enter_resp && !txn_valid;
      busy_d  = (state_d != IDLE);
      mem_we  = enter_resp && txn_we && txn_valid && !reset;
   end

   // FSM and registered outputs; reset aborts any transaction in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
         rdata_q <= 32'd0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   // Storage array is never reset; writes commit lane-by-lane on entry to RESP.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (txn_be[i]) begin
               mem[txn_idx][8*i +: 8] <= txn_wdata[8*i +: 8];
            end
         end
      end
   end

   assign rdata = rdata_q;
   assign ready = ready_q;
   assign err   = err_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_multicycle_mem.sv
// Scoreboard bench for multicycle_mem: a LATENCY=2 instance and a LATENCY=1
// instance, driven with directed vectors whose responses are worked out by hand.
module tb_multicycle_mem;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          readyCycle;
      int          tag;
   } exp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, we0, req1, we1;
   logic [31:0] addr0, wdata0, addr1, wdata1;
   logic [3:0]  be0, be1;
   logic [31:0] rdata0, rdata1;
   logic        ready0, err0, busy0, ready1, err1, busy1;

   int   cycle = 0;
   int   total = 0;
   int   bad   = 0;
   exp_t q0[$];
   exp_t q1[$];
   bit   prevReady[2];

   multicycle_mem #(.DEPTH_WORDS(64), .LATENCY(2)) dut0 (
      .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0),
      .wdata(wdata0), .be(be0), .rdata(rdata0), .ready(ready0), .err(err0),
      .busy(busy0)
   );

   multicycle_mem #(.DEPTH_WORDS(64), .LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1),
      .wdata(wdata1), .be(be1), .rdata(rdata1), .ready(ready1), .err(err1),
      .busy(busy1)
   );

   // Free-running clock and a cycle counter used to time ready pulses.
   always #5 clk = ~clk;

   // Cycle count advances on every rising edge.
   always @(posedge clk) cycle <= cycle + 1;

   function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h", nm, act, req);
      end
   endfunction

   function automatic void failNow(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", nm, act, req);
   endfunction

   // Pops the expected response when the DUT presents ready and compares it.
   task automatic checkOutput(input int which);
      logic        rdy, er;
      logic [31:0] rd;
      exp_t        e;
      int          qs;
      rdy = (which == 0) ? ready0 : ready1;
      er  = (which == 0) ? err0 : err1;
      rd  = (which == 0) ? rdata0 : rdata1;
      qs  = (which == 0) ? q0.size() : q1.size();
      if (rdy) begin
         if (prevReady[which]) failNow($sformatf("dut%0d_ready_twice", which), 32'd1, 32'd0);
         if (qs == 0) begin
            failNow($sformatf("dut%0d_unexpected_ready", which), 32'd1, 32'd0);
         end else begin
            e = (which == 0) ? q0.pop_front() : q1.pop_front();
            cmp($sformatf("dut%0d_txn%0d_err", which, e.tag), {31'd0, er}, {31'd0, e.err});
            cmp($sformatf("dut%0d_txn%0d_rdata", which, e.tag), rd, e.rdata);
            cmp($sformatf("dut%0d_txn%0d_cycle", which, e.tag), 32'(cycle), 32'(e.readyCycle));
         end
      end else begin
         if (er) failNow($sformatf("dut%0d_err_without_ready", which), 32'd1, 32'd0);
         if (qs != 0) begin
            e = (which == 0) ? q0[0] : q1[0];
            if (cycle > e.readyCycle) begin
               failNow($sformatf("dut%0d_txn%0d_missed_ready", which, e.tag), 32'(cycle), 32'(e.readyCycle));
               if (which == 0) void'(q0.pop_front());
               else void'(q1.pop_front());
            end
         end
      end
      prevReady[which] = rdy;
   endtask

   task automatic monitorLoop();
      forever begin
         @(negedge clk);
         checkOutput(0);
         checkOutput(1);
      end
   endtask

   // Waits at negedges for the selected DUT to be idle, bounded.
   task automatic waitIdle(input int which);
      int n = 0;
      while (((which == 0) ? busy0 : busy1) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) failNow($sformatf("dut%0d_idle_timeout", which), 32'd1, 32'd0);
   endtask

   // Issues one request at a negedge, records its expected response when
   // accepted, then scrambles the inputs so the in-flight transaction is
   // shown to be independent of them.
   task automatic applyStimulus(input int which, input vec_t v, input int tag, input bit expectResp);
      exp_t e;
      waitIdle(which);
      if (which == 0) begin
         req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; be0 = v.be;
      end else begin
         req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; be1 = v.be;
      end
      @(posedge clk);
      #1;
      e.rdata      = v.rdata;
      e.err        = v.err;
      e.readyCycle = cycle + ((which == 0) ? 1 : 0);
      e.tag        = tag;
      if (expectResp) begin
         if (which == 0) q0.push_back(e);
         else q1.push_back(e);
      end
      @(negedge clk);
      if (which == 0) begin
         req0 = 1'b0; we0 = $urandom; addr0 = $urandom; wdata0 = $urandom; be0 = 4'($urandom);
      end else begin
         req1 = 1'b0; we1 = $urandom; addr1 = $urandom; wdata1 = $urandom; be1 = 4'($urandom);
      end
   endtask

   vec_t vecA[10];
   vec_t vecB[4];
   vec_t vecL1[3];

   initial begin
      exp_t e;
      vec_t v;
      int   c0;
      int   n;

      vecA[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 1'b0, 32'h00000000};
      vecA[1] = '{1'b0, 32'h10,  32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
      vecA[2] = '{1'b1, 32'h10,  32'h000000AA, 4'h1, 1'b0, 32'hDEADBEEF};
      vecA[3] = '{1'b0, 32'h10,  32'h0,        4'h0, 1'b0, 32'hDEADBEAA};
      vecA[4] = '{1'b0, 32'h12,  32'h0,        4'h0, 1'b1, 32'h00000000};
      vecA[5] = '{1'b0, 32'h100, 32'h0,        4'h0, 1'b1, 32'h00000000};
      vecA[6] = '{1'b1, 32'h110, 32'h11111111, 4'hF, 1'b1, 32'h00000000};
      vecA[7] = '{1'b1, 32'h10,  32'h00000000, 4'h0, 1'b0, 32'h00000000};
      vecA[8] = '{1'b0, 32'h10,  32'h0,        4'h0, 1'b0, 32'hDEADBEAA};
      vecA[9] = '{1'b1, 32'h20,  32'h0BADF00D, 4'hF, 1'b0, 32'hDEADBEAA};

      vecB[0] = '{1'b0, 32'h20,       32'h0,        4'h0, 1'b0, 32'h0BADF00D};
      vecB[1] = '{1'b1, 32'hFC,       32'hA5A5A5A5, 4'hF, 1'b0, 32'h0BADF00D};
      vecB[2] = '{1'b0, 32'hFC,       32'h0,        4'h0, 1'b0, 32'hA5A5A5A5};
      vecB[3] = '{1'b0, 32'h80000010, 32'h0,        4'h0, 1'b1, 32'h00000000};

      vecL1[0] = '{1'b1, 32'h8, 32'h13579BDF, 4'hF, 1'b0, 32'h00000000};
      vecL1[1] = '{1'b0, 32'h8, 32'h0,        4'h0, 1'b0, 32'h13579BDF};
      vecL1[2] = '{1'b0, 32'h9, 32'h0,        4'h0, 1'b1, 32'h00000000};

      reset = 1'b1;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; be1 = '0;
      fork
         monitorLoop();
      join_none

      repeat (3) @(posedge clk);
      @(negedge clk);
      cmp("reset_ready", {31'd0, ready0}, 32'd0);
      cmp("reset_err",   {31'd0, err0},   32'd0);
      cmp("reset_busy",  {31'd0, busy0},  32'd0);
      cmp("reset_rdata", rdata0,          32'd0);
      reset = 1'b0;

      $display("[TB] directed transactions, LATENCY=2");
      for (int i = 0; i < 10; i++) applyStimulus(0, vecA[i], i, 1'b1);

      $display("[TB] req held high continuously");
      waitIdle(0);
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; wdata0 = '0; be0 = '0;
      @(posedge clk);
      #1;
      c0 = cycle;
      for (int k = 0; k < 3; k++) begin
         e.rdata = 32'hDEADBEAA; e.err = 1'b0; e.readyCycle = c0 + 1 + 3*k; e.tag = 100 + k;
         q0.push_back(e);
      end
      repeat (8) @(posedge clk);
      @(negedge clk);
      req0 = 1'b0;

      $display("[TB] reset while a write waits");
      v = '{1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0, 32'h0};
      applyStimulus(0, v, 200, 1'b0);
      reset = 1'b1;
      #1;
      cmp("abort_busy",  {31'd0, busy0},  32'd0);
      cmp("abort_ready", {31'd0, ready0}, 32'd0);
      cmp("abort_err",   {31'd0, err0},   32'd0);
      cmp("abort_rdata", rdata0,          32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 4; i++) applyStimulus(0, vecB[i], 300 + i, 1'b1);

      $display("[TB] directed transactions, LATENCY=1");
      for (int i = 0; i < 3; i++) applyStimulus(1, vecL1[i], 400 + i, 1'b1);

      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 30) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      cmp("dut0_queue_drained", 32'(q0.size()), 32'd0);
      cmp("dut1_queue_drained", 32'(q1.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
